// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential 8-by-4 restoring divider.
package divider_pkg;

   localparam int DIVIDEND_W = 8;
   localparam int DIVISOR_W  = 4;

   // Quotient reported when the divisor is zero.
   localparam logic [DIVIDEND_W-1:0] DBZ_QUOTIENT = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/divider_8by4_seq_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
interface divider_8by4_seq_if
   import divider_pkg::*;
#(
   parameter int DW_DIVIDEND = DIVIDEND_W,
   parameter int DW_DIVISOR  = DIVISOR_W
) ();

   logic                   start;
   logic [DW_DIVIDEND-1:0] DIVIDEND;
   logic [DW_DIVISOR-1:0]  DIVISOR;
   logic [DW_DIVIDEND-1:0] QUOTIENT;
   logic [DW_DIVISOR-1:0]  REMAINDER;
   logic                   busy;
   logic                   done;
   logic                   div_by_zero;

   modport master (
      output start, DIVIDEND, DIVISOR,
      input  QUOTIENT, REMAINDER, busy, done, div_by_zero
   );

   modport slave (
      input  start, DIVIDEND, DIVISOR,
      output QUOTIENT, REMAINDER, busy, done, div_by_zero
   );

endinterface

// File: rtl/divider_8by4_seq_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, restore on borrow.
module div_step #(
   parameter int W = 4
) (
   input  logic [W:0]   rem_in,
   input  logic         bit_in,
   input  logic [W-1:0] divisor,
   output logic [W:0]   rem_out,
   output logic         q_bit
);

   logic [W+1:0] shifted;
   logic [W+1:0] trial;

   // Partial remainder is always below the divisor, so the borrow lands in the top bit.
   always_comb begin
      shifted = {rem_in, bit_in};
      trial   = shifted - {2'b00, divisor};
      q_bit   = ~trial[W+1];
      rem_out = q_bit ? trial[W:0] : shifted[W:0];
   end

endmodule

// File: rtl/divider_8by4_seq.sv
// Sequential unsigned divider: one restoring step per clock, MSB first, with divide-by-zero flag.
module divider_8by4_seq
   import divider_pkg::*;
#(
   parameter int DW_DIVIDEND = DIVIDEND_W,
   parameter int DW_DIVISOR  = DIVISOR_W
) (
   input logic               clk,
   input logic               rst,
   divider_8by4_seq_if.slave bus
);

   localparam int             CW   = $clog2(DW_DIVIDEND + 1);
   localparam logic [CW-1:0]  LAST = CW'(DW_DIVIDEND - 1);

   state_t                 state, state_next;
   logic [CW-1:0]          cnt;
   logic [DW_DIVIDEND-1:0] quotient_r;
   logic [DW_DIVISOR-1:0]  remainder_r;
   logic                   dbz_r;

   logic [DW_DIVIDEND-1:0] dvd_r;
   logic [DW_DIVISOR-1:0]  dvs_r;
   logic [DW_DIVISOR:0]    rem_r;
   logic [DW_DIVISOR:0]    rem_next;
   logic                   q_bit;

   logic busy, done, load, step, finish;

   div_step #(.W(DW_DIVISOR)) u_step (
      .rem_in  (rem_r),
      .bit_in  (dvd_r[DW_DIVIDEND-1]),
      .divisor (dvs_r),
      .rem_out (rem_next),
      .q_bit   (q_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      load       = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load       = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            busy = 1'b1;
            if (dbz_r) begin
               finish     = 1'b1;
               state_next = DONE;
            end else begin
               step = 1'b1;
               if (cnt == LAST) begin
                  finish     = 1'b1;
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Ports only change on the finishing edge, so no partial quotient is ever visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         dbz_r       <= 1'b0;
         quotient_r  <= '0;
         remainder_r <= '0;
      end else begin
         if (load) begin
            cnt   <= '0;
            dbz_r <= (bus.DIVISOR == '0);
         end else if (step) begin
            cnt <= cnt + CW'(1);
         end
         if (finish) begin
            if (dbz_r) begin
               quotient_r  <= DW_DIVIDEND'(DBZ_QUOTIENT);
               remainder_r <= dvd_r[DW_DIVISOR-1:0];
            end else begin
               quotient_r  <= {dvd_r[DW_DIVIDEND-2:0], q_bit};
               remainder_r <= rem_next[DW_DIVISOR-1:0];
            end
         end
      end
   end

   // Dividend register doubles as the quotient shift register while stepping.
   always_ff @(posedge clk) begin
      if (load) begin
         dvd_r <= bus.DIVIDEND;
         dvs_r <= bus.DIVISOR;
         rem_r <= '0;
      end else if (step) begin
         dvd_r <= {dvd_r[DW_DIVIDEND-2:0], q_bit};
         rem_r <= rem_next;
      end
   end

   assign bus.QUOTIENT    = quotient_r;
   assign bus.REMAINDER   = remainder_r;
   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.div_by_zero = done & dbz_r;

endmodule

// File: tb/tb_divider_8by4_seq.sv
// Directed and random checks for the sequential 8-by-4 divider.
module tb_divider_8by4_seq;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   logic [7:0] q;
   logic [3:0] r;
   logic       dz;
   logic       busy1;
   logic       done_after;
   logic       dz_after;
   int         lat;

   divider_8by4_seq_if #(.DW_DIVIDEND(8), .DW_DIVISOR(4)) bus ();

   divider_8by4_seq #(.DW_DIVIDEND(8), .DW_DIVISOR(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Issue one division from IDLE and wait (bounded) for done; lat counts edges from the accepting one.
   task automatic run_op(input logic [7:0] a, input logic [3:0] b);
      bus.start    = 1'b1;
      bus.DIVIDEND = a;
      bus.DIVISOR  = b;
      tick();
      bus.start = 1'b0;
      busy1     = bus.busy;
      lat       = 1;
      while (!bus.done && lat < 30) begin
         tick();
         lat++;
      end
      q  = bus.QUOTIENT;
      r  = bus.REMAINDER;
      dz = bus.div_by_zero;
      tick();
      done_after = bus.done;
      dz_after   = bus.div_by_zero;
   endtask

   task automatic test_reset;
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.DIVIDEND = '0;
      bus.DIVISOR  = '0;
      repeat (3) tick();
      total++; if (bus.QUOTIENT !== 8'd0) begin bad++; $display("FAIL reset_q: got %0d want 0", bus.QUOTIENT); end
      total++; if (bus.REMAINDER !== 4'd0) begin bad++; $display("FAIL reset_r: got %0d want 0", bus.REMAINDER); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
      total++; if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero); end
      rst = 1'b0;
   endtask

   task automatic test_basic;
      run_op(8'd200, 4'd7);
      total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy1); end
      total++; if (lat != 9) begin bad++; $display("FAIL basic_latency: got %0d want 9", lat); end
      total++; if (q !== 8'd28) begin bad++; $display("FAIL basic_q: got %0d want 28", q); end
      total++; if (r !== 4'd4) begin bad++; $display("FAIL basic_r: got %0d want 4", r); end
      total++; if (dz !== 1'b0) begin bad++; $display("FAIL basic_dbz: got %b want 0", dz); end
      total++; if (done_after !== 1'b0) begin bad++; $display("FAIL basic_done_width: got %b want 0", done_after); end
   endtask

   task automatic test_limits;
      run_op(8'd255, 4'd1);
      total++; if (q !== 8'd255) begin bad++; $display("FAIL lim255_q: got %0d want 255", q); end
      total++; if (r !== 4'd0) begin bad++; $display("FAIL lim255_r: got %0d want 0", r); end
      run_op(8'd5, 4'd9);
      total++; if (q !== 8'd0) begin bad++; $display("FAIL lim5_q: got %0d want 0", q); end
      total++; if (r !== 4'd5) begin bad++; $display("FAIL lim5_r: got %0d want 5", r); end
      total++; if (lat != 9) begin bad++; $display("FAIL lim5_latency: got %0d want 9", lat); end
   endtask

   task automatic test_div_zero;
      run_op(8'd13, 4'd0);
      total++; if (lat != 2) begin bad++; $display("FAIL dbz_latency: got %0d want 2", lat); end
      total++; if (q !== 8'hFF) begin bad++; $display("FAIL dbz_q: got %h want ff", q); end
      total++; if (r !== 4'hD) begin bad++; $display("FAIL dbz_r: got %h want d", r); end
      total++; if (dz !== 1'b1) begin bad++; $display("FAIL dbz_flag: got %b want 1", dz); end
      total++; if (done_after !== 1'b0) begin bad++; $display("FAIL dbz_done_width: got %b want 0", done_after); end
      total++; if (dz_after !== 1'b0) begin bad++; $display("FAIL dbz_flag_after: got %b want 0", dz_after); end
   endtask

   task automatic test_start_while_busy;
      int dcount;
      logic [7:0] dq;
      logic [3:0] dr;
      dcount = 0;
      dq = '0;
      dr = '0;
      bus.start    = 1'b1;
      bus.DIVIDEND = 8'd200;
      bus.DIVISOR  = 4'd7;
      tick();
      for (int c = 1; c <= 20; c++) begin
         if (bus.done) begin
            dcount++;
            dq = bus.QUOTIENT;
            dr = bus.REMAINDER;
         end
         bus.start = (c == 3);
         if (c == 3) begin
            bus.DIVIDEND = 8'd99;
            bus.DIVISOR  = 4'd3;
         end
         tick();
      end
      bus.start = 1'b0;
      total++; if (dcount != 1) begin bad++; $display("FAIL busy_start_pulses: got %0d want 1", dcount); end
      total++; if (dq !== 8'd28) begin bad++; $display("FAIL busy_start_q: got %0d want 28", dq); end
      total++; if (dr !== 4'd4) begin bad++; $display("FAIL busy_start_r: got %0d want 4", dr); end
   endtask

   task automatic test_reset_mid_op;
      int dcount;
      dcount = 0;
      bus.start    = 1'b1;
      bus.DIVIDEND = 8'd200;
      bus.DIVISOR  = 4'd7;
      tick();
      bus.start = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      #1;
      total++; if (bus.QUOTIENT !== 8'd0) begin bad++; $display("FAIL midrst_q: got %0d want 0", bus.QUOTIENT); end
      total++; if (bus.REMAINDER !== 4'd0) begin bad++; $display("FAIL midrst_r: got %0d want 0", bus.REMAINDER); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
      tick();
      rst = 1'b0;
      for (int c = 0; c < 15; c++) begin
         if (bus.done) dcount++;
         tick();
      end
      total++; if (dcount != 0) begin bad++; $display("FAIL midrst_no_done: got %0d want 0", dcount); end
      run_op(8'd100, 4'd10);
      total++; if (q !== 8'd10) begin bad++; $display("FAIL midrst_next_q: got %0d want 10", q); end
      total++; if (r !== 4'd0) begin bad++; $display("FAIL midrst_next_r: got %0d want 0", r); end
      total++; if (lat != 9) begin bad++; $display("FAIL midrst_next_latency: got %0d want 9", lat); end
   endtask

   task automatic test_back_to_back;
      int dcount;
      int t0;
      int t1;
      int qbad;
      dcount = 0;
      t0     = -1;
      t1     = -1;
      qbad   = 0;
      bus.start    = 1'b1;
      bus.DIVIDEND = 8'd60;
      bus.DIVISOR  = 4'd7;
      tick();
      for (int c = 1; c <= 30; c++) begin
         if (bus.done) begin
            dcount++;
            if (t0 < 0) t0 = c;
            else if (t1 < 0) t1 = c;
            if (bus.QUOTIENT !== 8'd8 || bus.REMAINDER !== 4'd4) qbad++;
         end
         if (c == 30) bus.start = 1'b0;
         tick();
      end
      repeat (12) tick();
      total++; if (dcount != 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", dcount); end
      total++; if (t0 != 9) begin bad++; $display("FAIL b2b_first: got %0d want 9", t0); end
      total++; if (t1 - t0 != 10) begin bad++; $display("FAIL b2b_period: got %0d want 10", t1 - t0); end
      total++; if (qbad != 0) begin bad++; $display("FAIL b2b_values: got %0d wrong results want 0", qbad); end
   endtask

   task automatic test_random;
      logic [7:0] a;
      logic [3:0] b;
      int chk;
      for (int i = 0; i < 1000; i++) begin
         a = 8'($urandom_range(0, 255));
         b = 4'($urandom_range(1, 15));
         run_op(a, b);
         chk = int'(q) * int'(b) + int'(r);
         total++; if (chk != int'(a)) begin bad++; $display("FAIL rand_identity: %0d/%0d got q=%0d r=%0d", a, b, q, r); end
         total++; if (r >= b) begin bad++; $display("FAIL rand_rem_range: %0d/%0d got r=%0d want <%0d", a, b, r, b); end
         total++; if (lat != 9) begin bad++; $display("FAIL rand_latency: %0d/%0d got %0d want 9", a, b, lat); end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_basic();
      test_limits();
      test_div_zero();
      test_start_while_busy();
      test_reset_mid_op();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/divider_8by4_seq.md
DIVIDER_8BY4_SEQ -- requirements
Module: divider_8by4_seq

Interface
REQ-001 The module SHALL have parameter DW_DIVIDEND, default 8, which sets the dividend and quotient width.
REQ-002 The module SHALL have parameter DW_DIVISOR, default 4, which sets the divisor and remainder width.
REQ-003 The design SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  request to divide; sampled only in IDLE.
REQ-007 DIVIDEND  input  8  unsigned dividend, captured on the accepting edge.
REQ-008 DIVISOR  input  4  unsigned divisor, captured on the accepting edge.
REQ-009 QUOTIENT  output  8  unsigned quotient, registered.
REQ-010 REMAINDER  output  4  unsigned remainder, registered.
REQ-011 busy  output  1  high while in BUSY.
REQ-012 done  output  1  single-cycle pulse when a result is valid.
REQ-013 div_by_zero  output  1  set with done when the captured DIVISOR is 0.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE, with these transitions:
- IDLE->BUSY on start.
- BUSY->DONE after the last step, or on the first BUSY edge if the divisor is 0.
- DONE->IDLE unconditionally.
REQ-015 On the accepting edge N, the module SHALL capture the operands, clear the partial remainder and set the step counter to 0.
REQ-016 Edges N+1..N+8 SHALL each perform one restoring step, MSB first:
- shift the 5-bit partial remainder left and bring in the next dividend bit;
- if the result is >= divisor, subtract the divisor and set the quotient bit to 1;
- otherwise set the quotient bit to 0.
REQ-017 For a nonzero divisor, done SHALL be high in the cycle after edge N+8, and QUOTIENT/REMAINDER SHALL be valid in that same cycle (latency 9 cycles from start).
REQ-018 For a zero divisor:
- done and div_by_zero SHALL be high in the cycle after edge N+1;
- QUOTIENT SHALL be 8'hFF and REMAINDER SHALL be DIVIDEND[3:0].
REQ-019 done SHALL be high for exactly one cycle per accepted start.
REQ-020 div_by_zero SHALL be low whenever done is low.
REQ-021 QUOTIENT and REMAINDER SHALL hold the last result until the next result is written in DONE; no intermediate values SHALL appear on these ports.
REQ-022 start SHALL be ignored in BUSY and DONE; no queuing.
REQ-023 start held high continuously SHALL yield back-to-back operations, one every 10 cycles (IDLE one cycle between).
REQ-024 The result SHALL satisfy DIVIDEND == QUOTIENT*DIVISOR + REMAINDER with REMAINDER < DIVISOR, for all nonzero divisors.
REQ-025 Intermediate arithmetic SHALL use a 5-bit partial remainder so that the trial subtraction never overflows.

Reset
REQ-026 While rst is high, the module SHALL be in state IDLE with these values:
- QUOTIENT = 0 and REMAINDER = 0;
- busy = 0, done = 0, div_by_zero = 0;
- step counter = 0.
REQ-027 rst asserted mid-operation SHALL abort the division immediately; no done pulse SHALL follow.
REQ-028 The first start after rst deasserts SHALL be accepted on the first rising edge.

Structure
REQ-029 Package divider_pkg SHALL hold:
- the state enum (IDLE, BUSY, DONE);
- the width constants;
- the divide-by-zero quotient constant 8'hFF.
REQ-030 The combinational trial-subtract step SHALL be a sub-module div_step with:
- inputs: partial remainder, next bit, divisor;
- outputs: new partial remainder, quotient bit.
REQ-031 The FSM, the counter and the output registers SHALL reside in divider_8by4_seq.

Verification
REQ-032 Basic division: DIVIDEND=200, DIVISOR=7, start for 1 cycle -> done 9 cycles later with QUOTIENT=28, REMAINDER=4, div_by_zero=0.
REQ-033 Limits: 255/1 -> QUOTIENT=255, REMAINDER=0; 5/9 -> QUOTIENT=0, REMAINDER=5.
REQ-034 Divide by zero: 13/0 -> done 2 cycles after start with QUOTIENT=8'hFF, REMAINDER=4'hD, div_by_zero=1.
REQ-035 Start while busy: start 200/7, then pulse start with 99/3 at cycle 4 -> only the 28 r 4 result appears and exactly one done pulse occurs.
REQ-036 Reset mid-operation: rst pulsed at cycle 5 of a division -> outputs go to 0 and no done follows; a fresh 100/10 start then gives QUOTIENT=10, REMAINDER=0.
REQ-037 Randomized: the bench SHALL run 1000 random operand pairs and check REQ-024 plus the 9-cycle latency.
